// File: rtl/c86_sram_resp.sv
// c86_sram_resp: memory-side responder for the c86 byte bus (a, i, o, w, ce).
// Each access is served from a 16-bit asynchronous SRAM with WAIT_CYCLES
// wait states. The core is stalled by holding ce low until the byte is ready.
// Writes at or above ROM_BASE are turned into reads, which protects the BIOS.
// Optional feature macro: C86_RESP_LINEBUF_EN adds a one-word read buffer.
// All SRAM strobes are registered. The address phase is decoded from the live
// bus in S_ADDR, reaches the pins on the S_ADDR exit edge, and is held
// through S_DATA.
module c86_sram_resp #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [19:0] ROM_BASE    = 20'hFF000
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic [19:0] a,
    input  logic [7:0]  o,
    input  logic        w,
    output logic [7:0]  i,
    output logic        ce,
    output logic [18:0] sram_a,
    input  logic [15:0] sram_dq_i,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_WAIT = 2'd1,
        S_DATA = 2'd2,
        S_ACK  = 2'd3
    } state_t;

    // Counter preload: S_WAIT exits when the counter reaches zero.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef C86_RESP_LINEBUF_EN
    localparam logic READ_BOTH_LANES = 1'b1;
`else
    localparam logic READ_BOTH_LANES = 1'b0;
`endif

    state_t      state_r;
    state_t      state_s;
    logic        a0_r;
    logic [7:0]  o_r;
    logic        wr_en_r;
    logic [3:0]  cnt_r;

    logic        cur_lsb_s;
    logic        cur_wr_s;
    logic        hit_s;
    logic [7:0]  buf_byte_s;

    logic        ce_s;
    logic        ce_n_s;
    logic        oe_n_s;
    logic        we_n_s;
    logic        ub_n_s;
    logic        lb_n_s;
    logic        dq_oe_s;

    // Current access attributes: live bus in S_ADDR, latched copies afterwards.
    always_comb begin
        if (state_r == S_ADDR) begin
            cur_lsb_s = a[0];
            cur_wr_s  = w & (a < ROM_BASE);
        end else begin
            cur_lsb_s = a0_r;
            cur_wr_s  = wr_en_r;
        end
    end

`ifdef C86_RESP_LINEBUF_EN
    logic        buf_valid_r;
    logic [18:0] buf_addr_r;
    logic [15:0] buf_data_r;

    // Buffer lookup: only plain reads can be answered from the buffer.
    always_comb begin
        if ((state_r == S_ADDR) && !w && buf_valid_r && (buf_addr_r == a[19:1])) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        if (a[0]) begin
            buf_byte_s = buf_data_r[15:8];
        end else begin
            buf_byte_s = buf_data_r[7:0];
        end
    end

    // Buffer fill on every SRAM read, byte write-through on enabled writes.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= 19'd0;
            buf_data_r  <= 16'd0;
        end else if (state_r == S_DATA) begin
            if (!wr_en_r) begin
                buf_valid_r <= 1'b1;
                buf_addr_r  <= sram_a;
                buf_data_r  <= sram_dq_i;
            end else if (buf_valid_r && (buf_addr_r == sram_a)) begin
                if (a0_r) begin
                    buf_data_r[15:8] <= o_r;
                end else begin
                    buf_data_r[7:0] <= o_r;
                end
            end
        end
    end
`else
    assign hit_s      = 1'b0;
    assign buf_byte_s = 8'h00;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_r <= S_ADDR;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_ADDR: begin
                if (hit_s) begin
                    state_s = S_ACK;
                end else if (WAIT_CYCLES == 0) begin
                    state_s = S_DATA;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_s = S_DATA;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DATA:  state_s = S_ACK;
            S_ACK:   state_s = S_ADDR;
            default: state_s = S_ADDR;
        endcase
    end

    // Output decode for the state being entered; registered below.
    always_comb begin
        ce_s    = 1'b0;
        ce_n_s  = 1'b1;
        oe_n_s  = 1'b1;
        we_n_s  = 1'b1;
        ub_n_s  = 1'b1;
        lb_n_s  = 1'b1;
        dq_oe_s = 1'b0;
        case (state_s)
            S_WAIT, S_DATA: begin
                ce_n_s = 1'b0;
                if (cur_wr_s) begin
                    we_n_s  = 1'b0;
                    dq_oe_s = 1'b1;
                end else begin
                    oe_n_s = 1'b0;
                end
                if (!cur_wr_s && READ_BOTH_LANES) begin
                    ub_n_s = 1'b0;
                    lb_n_s = 1'b0;
                end else begin
                    ub_n_s = ~cur_lsb_s;
                    lb_n_s = cur_lsb_s;
                end
            end
            S_ACK: begin
                ce_s = 1'b1;
                if (cur_wr_s) begin
                    dq_oe_s = 1'b1;
                end else begin
                    dq_oe_s = 1'b0;
                end
            end
            S_ADDR:  ce_s = 1'b0;
            default: ce_s = 1'b0;
        endcase
    end

    // Registered bus and SRAM outputs.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ce         <= 1'b0;
            i          <= 8'h00;
            sram_a     <= 19'd0;
            sram_dq_o  <= 16'h0000;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_ub_n  <= 1'b1;
            sram_lb_n  <= 1'b1;
        end else begin
            ce         <= ce_s;
            sram_dq_oe <= dq_oe_s;
            sram_ce_n  <= ce_n_s;
            sram_oe_n  <= oe_n_s;
            sram_we_n  <= we_n_s;
            sram_ub_n  <= ub_n_s;
            sram_lb_n  <= lb_n_s;
            if (state_r == S_ADDR) begin
                sram_a    <= a[19:1];
                sram_dq_o <= {o, o};
            end else begin
                sram_a    <= sram_a;
                sram_dq_o <= sram_dq_o;
            end
            // Writes return the written byte so read-after-write is coherent.
            if (state_r == S_DATA) begin
                if (wr_en_r) begin
                    i <= o_r;
                end else if (a0_r) begin
                    i <= sram_dq_i[15:8];
                end else begin
                    i <= sram_dq_i[7:0];
                end
            end else if (hit_s) begin
                i <= buf_byte_s;
            end else begin
                i <= i;
            end
        end
    end

    // Access latch and wait-state counter.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            a0_r    <= 1'b0;
            o_r     <= 8'h00;
            wr_en_r <= 1'b0;
            cnt_r   <= 4'd0;
        end else begin
            case (state_r)
                S_ADDR: begin
                    a0_r    <= a[0];
                    o_r     <= o;
                    wr_en_r <= cur_wr_s;
                    cnt_r   <= WAIT_LOAD;
                end
                S_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule

// File: doc/c86_sram_resp.md
Name: c86_sram_resp

Overview:
- Bus responder for the c86 core: the memory side of the c86 byte bus (a, i, o, w, ce).
- Serves each c86 access from a 16-bit-wide asynchronous external SRAM with configurable wait states.
- Stalls the core by holding ce low until the addressed byte is ready.
- Write-protects a BIOS ROM window at the top of the 1 MB space.

Parameters:
- WAIT_CYCLES, 1: SRAM access wait states inserted between address setup and data capture; range 0..15.
- ROM_BASE, 20'hFF000: c86 writes at addresses >= ROM_BASE are suppressed.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- a  in  20  c86 byte address.
- o  in  8  c86 write data.
- w  in  1  c86 write request.
- i  out  8  read data to c86.
- ce  out  1  clock enable to c86; high exactly one clock per completed access.
- sram_a  out  19  SRAM word address, equal to a[19:1].
- sram_dq_i  in  16  SRAM data in.
- sram_dq_o  out  16  SRAM data out, equal to {o,o}.
- sram_dq_oe  out  1  tristate enable for sram_dq_o.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active low.
- sram_ub_n, sram_lb_n  out  1 each  byte-lane enables, active low.

Behaviour:
Reset:
- While rst_n=0 at a rising edge: state=S_ADDR; ce=0, i=8'h00, sram_a=0, sram_dq_oe=0, all sram_*_n=1.
- Reset mid-access aborts immediately; sram_we_n is high on the same edge, and a partial write is acceptable.

States, in order S_ADDR -> S_WAIT -> S_DATA -> S_ACK -> S_ADDR:
- S_ADDR, 1 clk:
  - Latch a, o and w.
  - Latch wr_en = w & (a < ROM_BASE).
  - Drive sram_a, sram_ce_n=0 and the lane enable: a[0]=0 -> lb_n=0; a[0]=1 -> ub_n=0. The other lane stays 1.
  - Read: oe_n=0. Write: dq_oe=1.
- S_WAIT, WAIT_CYCLES clks: a 4-bit counter counts down. When WAIT_CYCLES=0 this state is skipped (S_ADDR -> S_DATA).
- S_DATA, 1 clk:
  - Read: i <= sram_dq_i lane selected by the latched a[0].
  - Write: i <= latched o, so read-after-write is coherent.
  - ROM-suppressed write: perform a read cycle instead and return the ROM byte.
- S_ACK, 1 clk:
  - ce=1, all strobes high, dq_oe still 1 for a write (data hold).
  - The core advances on this edge and presents the next a/o/w.
- S_ACK -> S_ADDR.

Write strobe and signal stability:
- sram_we_n=0 only in S_WAIT and S_DATA when wr_en=1.
- The address and lane enables are stable from S_ADDR through S_DATA.
- The address never changes while we_n=0.

Cadence and ce:
- Access period is WAIT_CYCLES+3 clocks; ce duty is 1 in WAIT_CYCLES+3.
- ce is never high in two consecutive clocks.
- i holds its value until the next S_DATA.
- a, o and w are sampled only in S_ADDR; changes at other times are ignored.

Optional Feature:
- Macro: C86_RESP_LINEBUF_EN.
- Enabled:
  - A one-word read buffer holds {valid, word address, 16-bit data}. It is filled on every SRAM read in S_DATA (both lanes captured; ub_n and lb_n both 0 on reads).
  - A read in S_ADDR whose a[19:1] matches a valid buffer entry goes S_ADDR -> S_ACK with i loaded from the buffer. SRAM strobes stay high and the period is 2 clocks.
  - An enabled write to the buffered word updates the matching byte of the buffer (write-through).
  - Reset clears valid.
- Disabled: no buffer. Every access takes the full path, and reads enable only the addressed lane.

Test Plan:
- WAIT_CYCLES=1, SRAM word 0x12345 = 16'hBEEF; read a=20'h2468B -> ce pulses 4 clocks after S_ADDR entry, i=8'hBE, ub_n=0, lb_n=1.
- Write a=20'h00010, o=8'h5A -> we_n low for exactly 2 clocks with sram_a=0x00008, lb_n=0, dq_o=16'h5A5A. A following read of 20'h00010 returns 8'h5A.
- Write a=20'hFF100, o=8'h00 -> we_n never low; i returns the existing ROM byte; ce cadence unchanged.
- WAIT_CYCLES=0 -> back-to-back reads give a ce period of exactly 3 clocks. Assert rst_n=0 during S_WAIT of a write -> we_n=1 and ce=0 on that edge, then restart in S_ADDR.
- With C86_RESP_LINEBUF_EN: read 20'h00100, then 20'h00101 -> second access completes in 2 clocks with i = high byte and no SRAM strobes. A write to 20'h00100 followed by a read returns the new byte from the buffer.
